// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register index/word widths, writeback requester IDs
// and the writeback stage record.
package cpu_types_pkg;

    localparam int unsigned INDEX_W = 5;
    localparam int unsigned WORD_W  = 32;

    typedef logic [INDEX_W-1:0] index_t;
    typedef logic [WORD_W-1:0]  word_t;

    localparam int unsigned RF_WB_NREQ = 3;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LSU = 1;
    localparam int unsigned REQ_CSR = 2;

    typedef struct packed {
        logic   valid;
        index_t index;
        word_t  data;
    } wb_stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester at or after ptr wins.
// The pointer register lives in the parent; next_ptr is one past the winner.
module rr_arbiter #(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic          enable,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] next_ptr
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = PW'((idx + 1) % N);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NREQ writeback sources.
// Define RF_ARB_FORWARD_EN to forward the in-flight write stage onto the read data outputs.
module regfile_write_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned NREQ  = RF_WB_NREQ,
    parameter int unsigned IDXW  = INDEX_W,
    parameter int unsigned DATAW = WORD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*IDXW-1:0]  req_index,
    input  logic [NREQ*DATAW-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  reg_write,
    output logic [IDXW-1:0]       write_index,
    output logic [DATAW-1:0]      write_data,
    input  logic [IDXW-1:0]       read_index1,
    input  logic [IDXW-1:0]       read_index2,
    input  logic [DATAW-1:0]      rf_read_data1,
    input  logic [DATAW-1:0]      rf_read_data2,
    output logic [DATAW-1:0]      read_data1,
    output logic [DATAW-1:0]      read_data2,
    output logic                  busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef struct packed {
        logic             valid;
        logic [IDXW-1:0]  index;
        logic [DATAW-1:0] data;
    } stage_t;

    stage_t           stage;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    next_ptr;
    logic [NREQ-1:0]  grant;
    logic             grant_en;
    logic [IDXW-1:0]  sel_index;
    logic [DATAW-1:0] sel_data;

    // Reset also masks grants so nothing is handshaken while the pipe flushes.
    assign grant_en = !hold && !rst;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr_arbiter (
        .req      (req_valid),
        .enable   (grant_en),
        .ptr      (rr_ptr),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    assign req_ready = grant;

    always_comb begin
        sel_index = '0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_index = req_index[i*IDXW +: IDXW];
                sel_data  = req_data[i*DATAW +: DATAW];
            end
        end
    end

    // The write port never stalls, so the stage drains every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage  <= '0;
            rr_ptr <= '0;
        end else if (|grant) begin
            stage.valid <= 1'b1;
            stage.index <= sel_index;
            stage.data  <= sel_data;
            rr_ptr      <= next_ptr;
        end else begin
            stage.valid <= 1'b0;
        end
    end

    assign reg_write   = stage.valid && (stage.index != '0);
    assign write_index = stage.index;
    assign write_data  = stage.data;
    assign busy        = stage.valid;

`ifdef RF_ARB_FORWARD_EN
    assign read_data1 = (reg_write && (stage.index == read_index1)) ? stage.data : rf_read_data1;
    assign read_data2 = (reg_write && (stage.index == read_index2)) ? stage.data : rf_read_data2;
`else
    logic unused_read_index;
    assign unused_read_index = ^{read_index1, read_index2};
    assign read_data1 = rf_read_data1;
    assign read_data2 = rf_read_data2;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of grant order and the write stage.
module tb_regfile_write_arbiter;
    import cpu_types_pkg::*;

    localparam int NREQ  = 3;
    localparam int IDXW  = 5;
    localparam int DATAW = 32;

    logic                  clk;
    logic                  rst;
    logic                  hold;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*IDXW-1:0]  req_index;
    logic [NREQ*DATAW-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  reg_write;
    logic [IDXW-1:0]       write_index;
    logic [DATAW-1:0]      write_data;
    logic [IDXW-1:0]       read_index1;
    logic [IDXW-1:0]       read_index2;
    logic [DATAW-1:0]      rf_read_data1;
    logic [DATAW-1:0]      rf_read_data2;
    logic [DATAW-1:0]      read_data1;
    logic [DATAW-1:0]      read_data2;
    logic                  busy;

    regfile_write_arbiter #(
        .NREQ  (NREQ),
        .IDXW  (IDXW),
        .DATAW (DATAW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hold          (hold),
        .req_valid     (req_valid),
        .req_index     (req_index),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .reg_write     (reg_write),
        .write_index   (write_index),
        .write_data    (write_data),
        .read_index1   (read_index1),
        .read_index2   (read_index2),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2),
        .read_data1    (read_data1),
        .read_data2    (read_data2),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks;
    int errors;

    // Reference model: pending write, round-robin start point, register file contents.
    int          m_ptr;
    logic        m_valid;
    logic [4:0]  m_index;
    logic [31:0] m_data;
    logic [31:0] m_rf  [32];
    logic [31:0] obs_rf[32];

    function automatic logic [NREQ-1:0] model_grant();
        logic [NREQ-1:0] one;
        one = 1;
        if (rst || hold) return '0;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return one << i;
        end
        return '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic [31:0] rfd);
`ifdef RF_ARB_FORWARD_EN
        if (m_valid && m_index != 0 && m_index == idx) return m_data;
`endif
        return rfd;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [4:0] idx,
                           input logic [31:0] d);
        req_valid[i]              = v;
        req_index[i*IDXW +: IDXW]  = idx;
        req_data[i*DATAW +: DATAW] = d;
    endtask

    // One clock: commit the model's view of this cycle at the edge, settle 1 time unit later.
    task automatic tick();
        logic [NREQ-1:0] g;
        g = model_grant();
        if (reg_write === 1'b1) obs_rf[write_index] = write_data;
        @(posedge clk);
        if (m_valid && m_index != 0) m_rf[m_index] = m_data;
        if (rst) begin
            m_valid = 0;
            m_index = 0;
            m_data  = 0;
            m_ptr   = 0;
        end else if (g != 0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) begin
                    m_valid = 1;
                    m_index = req_index[i*IDXW +: IDXW];
                    m_data  = req_data[i*DATAW +: DATAW];
                    m_ptr   = (i + 1) % NREQ;
                end
            end
        end else begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(1 + $urandom_range(30)), $urandom);
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (req_ready !== 3'b000) begin
                errors++;
                $display("FAIL reset_ready cycle %0d: got %b want 000", c, req_ready);
            end
            tick();
            checks++;
            if (reg_write !== 1'b0 || busy !== 1'b0 || write_index !== 5'd0 || write_data !== 32'd0)
            begin
                errors++;
                $display("FAIL reset_outputs: got rw=%b busy=%b idx=%0d data=%h want 0 0 0 0",
                         reg_write, busy, write_index, write_data);
            end
        end
        rst = 0;
        #1;
        checks++;
        if (req_ready !== 3'b001 || req_ready !== model_grant()) begin
            errors++;
            $display("FAIL reset_first_grant: got %b want 001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (reg_write !== 1'b1 || write_index !== req_index[4:0] || write_data !== req_data[31:0])
        begin
            errors++;
            $display("FAIL reset_first_write: got rw=%b idx=%0d data=%h want 1 %0d %h",
                     reg_write, write_index, write_data, req_index[4:0], req_data[31:0]);
        end
        tick();
    endtask

    task automatic test_single();
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        checks++;
        if (req_ready !== 3'b010) begin
            errors++;
            $display("FAIL single_ready: got %b want 010", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (reg_write !== 1'b1 || write_index !== 5'd5 || write_data !== 32'hDEADBEEF
            || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_write: got rw=%b idx=%0d data=%h busy=%b want 1 5 deadbeef 1",
                     reg_write, write_index, write_data, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got busy=%b rw=%b want 0 0", busy, reg_write);
        end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] one;
        one = 1;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(1 + $urandom_range(30)), $urandom);
        #1;
        for (int c = 0; c < 6; c++) begin
            logic [NREQ-1:0] want;
            want = one << (c % 3);
            checks++;
            if (req_ready !== want || req_ready !== model_grant()) begin
                errors++;
                $display("FAIL fair_grant cycle %0d: got %b want %b", c, req_ready, want);
            end
            tick();
            checks++;
            if (reg_write !== 1'b1 || write_index !== m_index || write_data !== m_data) begin
                errors++;
                $display("FAIL fair_write cycle %0d: got rw=%b idx=%0d data=%h want 1 %0d %h",
                         c, reg_write, write_index, write_data, m_index, m_data);
            end
            set_req(c % 3, 1'b1, 5'(1 + $urandom_range(30)), $urandom);
            #1;
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_x0_hold();
        set_req(0, 1'b1, 5'd0, $urandom);
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL x0_ready: got %b want 001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (busy !== 1'b1 || reg_write !== 1'b0 || write_index !== 5'd0) begin
            errors++;
            $display("FAIL x0_stage: got busy=%b rw=%b idx=%0d want 1 0 0",
                     busy, reg_write, write_index);
        end
        hold = 1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(1 + $urandom_range(30)), $urandom);
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (req_ready !== 3'b000) begin
                errors++;
                $display("FAIL hold_ready cycle %0d: got %b want 000", c, req_ready);
            end
            tick();
            checks++;
            if (busy !== 1'b0 || reg_write !== 1'b0) begin
                errors++;
                $display("FAIL hold_drain cycle %0d: got busy=%b rw=%b want 0 0",
                         c, busy, reg_write);
            end
        end
        hold = 0;
        #1;
        checks++;
        if (req_ready !== 3'b010) begin
            errors++;
            $display("FAIL hold_ptr_frozen: got %b want 010", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_conflict();
        do_reset();
        set_req(0, 1'b1, 5'd7, 32'h11);
        set_req(2, 1'b1, 5'd7, 32'h22);
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL conflict_first: got %b want 001", req_ready);
        end
        tick();
        req_valid[0] = 1'b0;
        #1;
        checks++;
        if (reg_write !== 1'b1 || write_index !== 5'd7 || write_data !== 32'h11
            || req_ready !== 3'b100) begin
            errors++;
            $display("FAIL conflict_write1: got rw=%b idx=%0d data=%h ready=%b want 1 7 11 100",
                     reg_write, write_index, write_data, req_ready);
        end
        tick();
        req_valid[2] = 1'b0;
        #1;
        checks++;
        if (reg_write !== 1'b1 || write_index !== 5'd7 || write_data !== 32'h22) begin
            errors++;
            $display("FAIL conflict_write2: got rw=%b idx=%0d data=%h want 1 7 22",
                     reg_write, write_index, write_data);
        end
        tick();
        checks++;
        if (obs_rf[7] !== 32'h22 || obs_rf[7] !== m_rf[7]) begin
            errors++;
            $display("FAIL conflict_last_wins: got %h want 22", obs_rf[7]);
        end
    endtask

    task automatic test_forward();
        logic [31:0] want1;
`ifdef RF_ARB_FORWARD_EN
        want1 = 32'hCAFE;
`else
        want1 = 32'h0;
`endif
        set_req(1, 1'b1, 5'd9, 32'hCAFE);
        #1;
        tick();
        req_valid     = '0;
        read_index1   = 5'd9;
        rf_read_data1 = 32'h0;
        read_index2   = 5'd4;
        rf_read_data2 = 32'h5555;
        #1;
        checks++;
        if (read_data1 !== want1 || read_data2 !== 32'h5555) begin
            errors++;
            $display("FAIL forward_hit: got rd1=%h rd2=%h want %h 00005555",
                     read_data1, read_data2, want1);
        end
        tick();
        checks++;
        if (read_data1 !== 32'h0) begin
            errors++;
            $display("FAIL forward_idle: got %h want 0", read_data1);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] g;
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            hold          = ($urandom_range(4) == 0);
            rst           = ($urandom_range(59) == 0);
            read_index1   = ($urandom_range(1) == 1) ? m_index : 5'($urandom);
            read_index2   = ($urandom_range(1) == 1) ? m_index : 5'($urandom);
            rf_read_data1 = $urandom;
            rf_read_data2 = $urandom;
            #1;
            g = model_grant();
            checks++;
            if (req_ready !== g) begin
                errors++;
                $display("FAIL rand_grant cycle %0d: got %b want %b", c, req_ready, g);
            end
            checks++;
            if (read_data1 !== model_read(read_index1, rf_read_data1)
                || read_data2 !== model_read(read_index2, rf_read_data2)) begin
                errors++;
                $display("FAIL rand_read cycle %0d: got %h %h want %h %h", c,
                         read_data1, read_data2, model_read(read_index1, rf_read_data1),
                         model_read(read_index2, rf_read_data2));
            end
            tick();
            checks++;
            if (reg_write !== (m_valid && m_index != 0) || busy !== m_valid
                || write_index !== m_index || write_data !== m_data) begin
                errors++;
                $display("FAIL rand_stage cycle %0d: got rw=%b busy=%b idx=%0d data=%h want %b %b %0d %h",
                         c, reg_write, busy, write_index, write_data,
                         (m_valid && m_index != 0), m_valid, m_index, m_data);
            end
            // Requesters only change their offer once it has been taken or was idle.
            for (int i = 0; i < NREQ; i++) begin
                if (g[i] || !req_valid[i])
                    set_req(i, ($urandom_range(2) != 0), 5'($urandom), $urandom);
            end
        end
        rst       = 0;
        hold      = 0;
        req_valid = '0;
        tick();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        clk           = 0;
        rst           = 1;
        hold          = 0;
        req_valid     = '0;
        req_index     = '0;
        req_data      = '0;
        read_index1   = '0;
        read_index2   = '0;
        rf_read_data1 = '0;
        rf_read_data2 = '0;
        m_ptr         = 0;
        m_valid       = 0;
        m_index       = 0;
        m_data        = 0;
        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = 0;
            obs_rf[i] = 0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_fairness();
        test_x0_hold();
        test_conflict();
        test_forward();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
